probe_cmd_parser: RTL and testbench
===================================

Name: probe_cmd_parser

Overview:
- Byte-stream command parser for the on-chip probe.
- Sits directly behind the UART bridge:
  - consumes host bytes that the bridge reads from the UART RX register;
  - returns response bytes that the bridge writes to the UART TX register.
- Decodes read and write commands into single-cycle accesses on a simple 8-bit-address / 32-bit-data probe register bus.

Parameters:
- TIMEOUT, 1000000: idle cycles allowed between bytes of one command before the partial command is discarded. Must be ≥2.
- ACK_BYTE, 8'hAA: response byte for a completed write.
- ERR_BYTE, 8'hEE: response byte for an unknown opcode.

Ports:
- clk  in  1  clock.
- m_aresetn  in  1  asynchronous active-low reset.
- in_valid  in  1  host byte valid; connects to bridge tx_valid.
- in_data  in  8  host byte; connects to bridge tx_data.
- in_ready  out  1  host byte accepted; connects to bridge tx_ready.
- out_valid  out  1  response byte valid; connects to bridge rx_valid.
- out_data  out  8  response byte; connects to bridge rx_data.
- out_ready  in  1  response byte accepted, may be a 1-cycle pulse; connects to bridge rx_ready.
- reg_addr  out  8  register index.
- reg_wdata  out  32  write data.
- reg_wen  out  1  write strobe, 1-cycle pulse.
- reg_ren  out  1  read strobe, 1-cycle pulse.
- reg_rdata  in  32  read data, valid exactly 1 cycle after reg_ren.

Behaviour:
- Reset values (asynchronous): state IDLE; out_valid 0; out_data 0; reg_wen 0; reg_ren 0; reg_addr 0; reg_wdata 0; in_ready 0. Reset mid-command or mid-response abandons it; nothing is replayed.
- Byte handshake:
  - Input byte accepted on in_valid && in_ready.
  - in_ready is high only in IDLE, ADDR and WDATA; low in all other states, so upstream must hold the byte.
- Command format, bytes in order:
  - Read: opcode 8'h01, then addr.
  - Write: opcode 8'h02, then addr, then 4 data bytes little-endian (first byte → wdata[7:0]).
- IDLE: on accepted byte:
  - 01 or 02: latch opcode, go to ADDR.
  - Any other value: load ERR_BYTE into the response buffer, count 1, go to TX.
- ADDR: on accepted byte:
  - Latch reg_addr.
  - Read: go to RDSTB.
  - Write: clear byte index, go to WDATA.
- WDATA: on accepted byte:
  - Store into reg_wdata[8*idx +: 8]; idx increments 0..3.
  - When idx==3 is accepted, go to WSTB.
- WSTB: reg_wen=1 for exactly this cycle. Load ACK_BYTE, count 1, go to TX.
- RDSTB: reg_ren=1 for exactly this cycle; go to RDCAP.
- RDCAP: capture reg_rdata into the 4-byte response buffer; count 4, byte 0 = rdata[7:0]; go to TX.
- TX:
  - out_valid=1 and out_data = current buffer byte, held stable until out_ready.
  - On handshake: next byte appears the following cycle.
  - After the last byte: out_valid drops the next cycle, go to IDLE.
- Latency:
  - Write: last data byte accepted at cycle N → reg_wen at N+1 → out_valid at N+2.
  - Read: addr byte accepted at N → reg_ren at N+1 → capture at N+2 → out_valid at N+3.
- Timeout:
  - A counter runs only in ADDR and WDATA and is cleared on every accepted byte.
  - When it reaches TIMEOUT-1 with no byte accepted: go to IDLE, discarding the partial command with no response and no bus access.
  - If a byte is accepted in the same cycle the timeout fires, the byte is accepted and the timeout is ignored.
  - The counter saturates and never wraps.
- reg_addr and reg_wdata hold their last values outside strobes.
- reg_wen and reg_ren are never high together.
- No pipelining: the next command's opcode is accepted only after the previous response fully drains.

Test Plan:
- Write: bytes 02,10,78,56,34,12 with in_valid continuous:
  - reg_wen pulses once with reg_addr=10, reg_wdata=32'h12345678;
  - out emits single byte AA;
  - in_ready low from WSTB until AA is accepted.
- Read: bytes 01,20 with bench returning reg_rdata=32'hDEADBEEF the cycle after reg_ren:
  - reg_ren pulses once with reg_addr=20;
  - out emits EF,BE,AD,DE in order.
- Backpressure: out_ready pulsed only every 7th cycle during the read response → each byte held stable until its pulse; 4 bytes total, no duplicates or drops.
- Unknown opcode 5A → out emits EE only; no reg_wen/reg_ren; the next 01,00 is decoded as a normal read.
- Timeout (TIMEOUT=16): send 02,10,11, then idle 20 cycles, then 01,30 → no reg_wen; read of address 30 executes normally.
- Reset: assert m_aresetn low during the 2nd response byte of a read → out_valid, reg_* strobes and in_ready go low immediately; after release the parser is in IDLE and a fresh write succeeds.

Source files
------------

// File: rtl/probe_cmd_parser_if.sv
// Signal bundle between the probe command parser, the UART bridge and the
// probe register file. The master view belongs to the parser. The slave view
// belongs to the surroundings: the bridge on the byte side and the register
// file on the bus side.
interface probe_cmd_parser_if;
  // host -> parser byte stream
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  // parser -> host response stream
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  // probe register bus
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wen;
  logic        reg_ren;
  logic [31:0] reg_rdata;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready,
    output reg_addr,
    output reg_wdata,
    output reg_wen,
    output reg_ren,
    input  reg_rdata
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready,
    input  reg_addr,
    input  reg_wdata,
    input  reg_wen,
    input  reg_ren,
    output reg_rdata
  );
endinterface

// File: rtl/probe_cmd_parser.sv
// Byte-stream command parser for the on-chip probe.
// Host bytes arrive from the UART bridge. Two commands are decoded:
//   read  : 01 addr           -> 4 response bytes (rdata, LSB first)
//   write : 02 addr d0 d1 d2 d3 -> 1 response byte (ACK_BYTE)
// Any other opcode is answered with ERR_BYTE. A partial command that stalls
// for TIMEOUT cycles is dropped silently. Only one command is in flight.
module probe_cmd_parser #(
  parameter int unsigned TIMEOUT  = 1000000,
  parameter logic [7:0]  ACK_BYTE = 8'hAA,
  parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
  input logic                clk,
  input logic                m_aresetn,
  probe_cmd_parser_if.master bus
);

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int             TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_WSTB  = 3'd3;
  localparam logic [2:0] S_RDSTB = 3'd4;
  localparam logic [2:0] S_RDCAP = 3'd5;
  localparam logic [2:0] S_TX    = 3'd6;

  logic [2:0]    state_reg, state_next;
  logic          is_wr_reg, is_wr_next;
  logic [1:0]    widx_reg, widx_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic [1:0]    tx_idx_reg, tx_idx_next;
  logic [1:0]    tx_last_reg, tx_last_next;
  logic [7:0]    addr_reg, addr_next;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic          reg_wen_reg;
  logic          reg_ren_reg;

  logic [31:0]   wdata_q;
  logic [31:0]   rsp_buf;

  logic          byte_fire;
  logic          out_fire;
  logic          opcode_ok;
  logic          collecting;
  logic          tmo_hit;
  logic          load_err;
  logic          load_ack;
  logic          load_rd;

  // in_ready/out_valid are registered copies of the state decode, so they
  // already qualify the handshakes without any extra state comparison.
  assign byte_fire  = bus.in_valid && in_ready_reg;
  assign out_fire   = out_valid_reg && bus.out_ready;
  assign opcode_ok  = (bus.in_data == OP_READ) || (bus.in_data == OP_WRITE);
  assign collecting = (state_reg == S_ADDR) || (state_reg == S_WDATA);
  // An accepted byte always wins over an expiring timer.
  assign tmo_hit    = collecting && !byte_fire && (tmo_reg == TMO_LAST);

  assign load_err   = byte_fire && (state_reg == S_IDLE) && !opcode_ok;
  assign load_ack   = (state_reg == S_WSTB);
  assign load_rd    = (state_reg == S_RDCAP);

  // Inter-byte idle counter: counts only while a command is half received,
  // restarts on every accepted byte, and saturates instead of wrapping.
  always_comb begin
    tmo_next = '0;
    if (collecting && !byte_fire) begin
      if (tmo_reg != '1) begin
        tmo_next = tmo_reg + 1'b1;
      end else begin
        tmo_next = tmo_reg;
      end
    end
  end

  // Command decode and response sequencing.
  always_comb begin
    state_next   = state_reg;
    is_wr_next   = is_wr_reg;
    widx_next    = widx_reg;
    tx_idx_next  = tx_idx_reg;
    tx_last_next = tx_last_reg;
    addr_next    = addr_reg;
    case (state_reg)
      S_IDLE: begin
        if (byte_fire) begin
          if (opcode_ok) begin
            is_wr_next = (bus.in_data == OP_WRITE);
            state_next = S_ADDR;
          end else begin
            tx_idx_next  = 2'd0;
            tx_last_next = 2'd0;
            state_next   = S_TX;
          end
        end
      end
      S_ADDR: begin
        if (byte_fire) begin
          addr_next = bus.in_data;
          if (is_wr_reg) begin
            widx_next  = 2'd0;
            state_next = S_WDATA;
          end else begin
            state_next = S_RDSTB;
          end
        end else if (tmo_hit) begin
          state_next = S_IDLE;
        end
      end
      S_WDATA: begin
        if (byte_fire) begin
          widx_next = widx_reg + 2'd1;
          if (widx_reg == 2'd3) begin
            state_next = S_WSTB;
          end
        end else if (tmo_hit) begin
          state_next = S_IDLE;
        end
      end
      S_WSTB: begin
        tx_idx_next  = 2'd0;
        tx_last_next = 2'd0;
        state_next   = S_TX;
      end
      S_RDSTB: begin
        state_next = S_RDCAP;
      end
      S_RDCAP: begin
        tx_idx_next  = 2'd0;
        tx_last_next = 2'd3;
        state_next   = S_TX;
      end
      S_TX: begin
        if (out_fire) begin
          if (tx_idx_reg == tx_last_reg) begin
            state_next = S_IDLE;
          end else begin
            tx_idx_next = tx_idx_reg + 2'd1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and handshake/strobe outputs, all derived from the next state so
  // every output is a clean flop and drops as soon as reset is asserted.
  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      state_reg     <= S_IDLE;
      is_wr_reg     <= 1'b0;
      widx_reg      <= 2'd0;
      tmo_reg       <= '0;
      tx_idx_reg    <= 2'd0;
      tx_last_reg   <= 2'd0;
      addr_reg      <= 8'h00;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      reg_wen_reg   <= 1'b0;
      reg_ren_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      is_wr_reg     <= is_wr_next;
      widx_reg      <= widx_next;
      tmo_reg       <= tmo_next;
      tx_idx_reg    <= tx_idx_next;
      tx_last_reg   <= tx_last_next;
      addr_reg      <= addr_next;
      in_ready_reg  <= (state_next == S_IDLE) || (state_next == S_ADDR) ||
                       (state_next == S_WDATA);
      out_valid_reg <= (state_next == S_TX);
      reg_wen_reg   <= (state_next == S_WSTB);
      reg_ren_reg   <= (state_next == S_RDSTB);
    end
  end

  // One byte lane each for write data and for the response buffer.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] wlane_reg;
    logic [7:0] rlane_reg;
    logic       wlane_we;

    assign wlane_we = byte_fire && (state_reg == S_WDATA) && (widx_reg == 2'(gi));

    // Write data lane: loaded when its byte index is accepted, held otherwise.
    always_ff @(posedge clk or negedge m_aresetn) begin
      if (!m_aresetn) begin
        wlane_reg <= 8'h00;
      end else if (wlane_we) begin
        wlane_reg <= bus.in_data;
      end
    end

    // Response lane: read data fills all lanes; single-byte replies use lane 0.
    always_ff @(posedge clk or negedge m_aresetn) begin
      if (!m_aresetn) begin
        rlane_reg <= 8'h00;
      end else if (load_rd) begin
        rlane_reg <= bus.reg_rdata[8*gi +: 8];
      end else if (gi == 0) begin
        if (load_ack) begin
          rlane_reg <= ACK_BYTE;
        end else if (load_err) begin
          rlane_reg <= ERR_BYTE;
        end
      end
    end

    assign wdata_q[8*gi +: 8] = wlane_reg;
    assign rsp_buf[8*gi +: 8] = rlane_reg;
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  // The buffer and index only change at a handshake, so the byte is stable
  // for as long as the bridge holds off out_ready.
  assign bus.out_data  = rsp_buf[8*tx_idx_reg +: 8];
  assign bus.reg_addr  = addr_reg;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_wen   = reg_wen_reg;
  assign bus.reg_ren   = reg_ren_reg;

endmodule

// File: tb/tb_probe_cmd_parser.sv
// Directed bench for probe_cmd_parser with TIMEOUT=16.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_probe_cmd_parser;

  logic        clk = 1'b0;
  logic        m_aresetn;
  logic [31:0] rd_value;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          wen_cnt = 0;
  int          ren_cnt = 0;
  int          both_cnt = 0;

  probe_cmd_parser_if bus ();

  probe_cmd_parser #(
    .TIMEOUT  (16),
    .ACK_BYTE (8'hAA),
    .ERR_BYTE (8'hEE)
  ) dut (
    .clk       (clk),
    .m_aresetn (m_aresetn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Register file model: read data appears the cycle after reg_ren.
  always @(posedge clk) begin
    bus.reg_rdata <= bus.reg_ren ? rd_value : 32'h0;
  end

  // Strobe counters.
  always @(posedge clk) begin
    if (bus.reg_wen) wen_cnt <= wen_cnt + 1;
    if (bus.reg_ren) ren_cnt <= ren_cnt + 1;
    if (bus.reg_wen && bus.reg_ren) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte; returns on the falling edge after it is accepted.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int n = 0; n < 200 && !done; n++) begin
      if (bus.in_ready) done = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("byte_accepted", 32'(done), 32'd1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int gap);
    int wen0;
    wen0 = wen_cnt;
    bus.out_ready = 1'b1;
    send_byte(8'h02);
    send_byte(a);
    repeat (gap) @(negedge clk);
    for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
    check("wr_wen", bus.reg_wen, 1);
    check("wr_ren", bus.reg_ren, 0);
    check("wr_addr", bus.reg_addr, a);
    check("wr_wdata", bus.reg_wdata, d);
    check("wr_inrdy_wstb", bus.in_ready, 0);
    @(negedge clk);
    check("wr_ovalid", bus.out_valid, 1);
    check("wr_ack", bus.out_data, 8'hAA);
    check("wr_inrdy_tx", bus.in_ready, 0);
    check("wr_wen_pulse", bus.reg_wen, 0);
    @(negedge clk);
    check("wr_ovalid_drop", bus.out_valid, 0);
    check("wr_inrdy_idle", bus.in_ready, 1);
    check("wr_wen_once", 32'(wen_cnt - wen0), 1);
    $display("write addr=%h data=%h gap=%0d done", a, d, gap);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] d);
    int ren0;
    ren0 = ren_cnt;
    rd_value = d;
    bus.out_ready = 1'b1;
    send_byte(8'h01);
    send_byte(a);
    check("rd_ren", bus.reg_ren, 1);
    check("rd_wen", bus.reg_wen, 0);
    check("rd_addr", bus.reg_addr, a);
    @(negedge clk);
    check("rd_ren_pulse", bus.reg_ren, 0);
    check("rd_cap_novalid", bus.out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rd_ovalid", bus.out_valid, 1);
      check("rd_byte", bus.out_data, d[8*k +: 8]);
    end
    @(negedge clk);
    check("rd_ovalid_drop", bus.out_valid, 0);
    check("rd_ren_once", 32'(ren_cnt - ren0), 1);
    $display("read addr=%h data=%h done", a, d);
  endtask

  initial begin
    int idx;
    int wen0;
    int ren0;
    m_aresetn     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    rd_value      = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ovalid", bus.out_valid, 0);
    check("rst_odata", bus.out_data, 0);
    check("rst_inrdy", bus.in_ready, 0);
    check("rst_wen", bus.reg_wen, 0);
    check("rst_ren", bus.reg_ren, 0);
    check("rst_addr", bus.reg_addr, 0);
    check("rst_wdata", bus.reg_wdata, 0);
    m_aresetn = 1'b1;
    @(negedge clk);
    check("idle_inrdy", bus.in_ready, 1);
    $display("reset state checked");

    // Basic write and read
    do_write(8'h10, 32'h12345678, 0);
    do_read(8'h20, 32'hDEADBEEF);

    // Read response under sparse out_ready pulses
    rd_value = 32'hCAFEF00D;
    bus.out_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h44);
    idx = 0;
    for (int k = 0; k < 60; k++) begin
      bus.out_ready = ((k % 7) == 6);
      if (idx < 4) begin
        if (bus.out_valid) begin
          check("bp_byte", bus.out_data, rd_value[8*idx +: 8]);
          if (bus.out_ready) idx++;
        end
      end else begin
        check("bp_no_extra", bus.out_valid, 0);
      end
      @(negedge clk);
    end
    check("bp_count", idx, 4);
    $display("backpressure read bytes=%0d", idx);

    // Unknown opcode
    wen0 = wen_cnt;
    ren0 = ren_cnt;
    bus.out_ready = 1'b1;
    send_byte(8'h5A);
    check("err_ovalid", bus.out_valid, 1);
    check("err_byte", bus.out_data, 8'hEE);
    check("err_inrdy", bus.in_ready, 0);
    @(negedge clk);
    check("err_ovalid_drop", bus.out_valid, 0);
    check("err_inrdy_idle", bus.in_ready, 1);
    check("err_no_wen", 32'(wen_cnt - wen0), 0);
    check("err_no_ren", 32'(ren_cnt - ren0), 0);
    $display("unknown opcode 5A answered");
    do_read(8'h00, 32'h11223344);

    // Stalled write discarded by timeout
    wen0 = wen_cnt;
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h11);
    repeat (20) @(negedge clk);
    check("tmo_inrdy", bus.in_ready, 1);
    check("tmo_ovalid", bus.out_valid, 0);
    do_read(8'h30, 32'h0BADF00D);
    check("tmo_no_wen", 32'(wen_cnt - wen0), 0);
    $display("timeout discard checked");

    // Byte arriving in the very cycle the timer expires is still taken
    do_write(8'h50, 32'h01020304, 15);

    // Reset during the second response byte of a read
    rd_value = 32'h89ABCDEF;
    bus.out_ready = 1'b1;
    send_byte(8'h01);
    send_byte(8'h60);
    repeat (3) @(negedge clk);
    check("rr_byte1", bus.out_data, 8'hCD);
    check("rr_ovalid", bus.out_valid, 1);
    #2 m_aresetn = 1'b0;
    #1;
    check("rr_ovalid_low", bus.out_valid, 0);
    check("rr_inrdy_low", bus.in_ready, 0);
    check("rr_wen_low", bus.reg_wen, 0);
    check("rr_ren_low", bus.reg_ren, 0);
    check("rr_addr_rst", bus.reg_addr, 0);
    repeat (2) @(negedge clk);
    m_aresetn = 1'b1;
    @(negedge clk);
    check("rr_idle_inrdy", bus.in_ready, 1);
    check("rr_idle_ovalid", bus.out_valid, 0);
    $display("reset mid-response checked");
    do_write(8'h70, 32'hA5A50F0F, 0);

    // Whole-run strobe bookkeeping
    check("total_wen", wen_cnt, 3);
    check("total_ren", ren_cnt, 5);
    check("wen_ren_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
